// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload block (FSM states, pad/fill values, bus widths).
package nvram_pkg;

    localparam int IDX_W  = 8;
    localparam int ADDR_W = 17;
    localparam int BYTE_W = 8;

    localparam logic [3:0] PAD_NIBBLE = 4'hF;
    localparam logic [7:0] OOR_FILL   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widens a 4-bit CMOS nibble into the byte the HPS sees.
    function automatic logic [7:0] pad_byte(input logic [3:0] nib);
        return {PAD_NIBBLE, nib};
    endfunction

endpackage

// File: rtl/nvram_upload_if.sv
// HPS ioctl upload bus: master is the HPS side, slave is nvram_upload.
interface nvram_upload_if;
    import nvram_pkg::*;

    logic              ioctl_upload;
    logic [IDX_W-1:0]  ioctl_index;
    logic [ADDR_W-1:0] ioctl_addr;
    logic              ioctl_rd;
    logic [BYTE_W-1:0] ioctl_din;
    logic              ioctl_wait;
    logic              ioctl_upload_req;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        input  ioctl_din, ioctl_wait, ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        output ioctl_din, ioctl_wait, ioctl_upload_req
    );

endinterface

// File: rtl/nvram_quiet_timer.sv
// Dirty flag plus write-quiet counter; pulses upload_req once the CPU has stopped writing for QUIET_CYCLES.
// Only built when NVRAM_AUTOSAVE_EN is defined.
`ifdef NVRAM_AUTOSAVE_EN
module nvram_quiet_timer #(
    parameter logic [23:0] QUIET_CYCLES = 24'd4800000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic cpu_nv_we,
    output logic upload_req
);

    logic        dirty_r;
    logic [23:0] count_r;
    logic        pulse_r;

    // A fresh write always restarts the quiet window, even on the expiry cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty_r <= 1'b0;
            count_r <= 24'd0;
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            if (cpu_nv_we) begin
                dirty_r <= 1'b1;
                count_r <= QUIET_CYCLES;
            end else if (dirty_r && (count_r <= 24'd1)) begin
                dirty_r <= 1'b0;
                count_r <= 24'd0;
                pulse_r <= 1'b1;
            end else if (dirty_r) begin
                count_r <= count_r - 24'd1;
            end
        end
    end

    assign upload_req = pulse_r;

endmodule
`endif

// File: rtl/nvram_upload.sv
// Serves HPS upload reads from the NVRAM read port, one byte per 3-cycle wait window.
// Optional autosave request generation is enabled with the NVRAM_AUTOSAVE_EN macro.
module nvram_upload
    import nvram_pkg::*;
#(
    parameter logic [7:0]  NV_INDEX     = 8'd4,
    parameter int          NV_AW        = 10,
    parameter logic [23:0] QUIET_CYCLES = 24'd4800000
) (
    input  logic             clk_sys,
    input  logic             reset,
    nvram_upload_if.slave    ioctl,
    output logic [NV_AW-1:0] nv_addr,
    input  logic [3:0]       nv_q,
    input  logic             cpu_nv_we
);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              oor_s;
    logic              oor_r;
    logic              wait_r;
    logic [7:0]        din_r;
    logic [NV_AW-1:0]  nv_addr_r;

    assign oor_s = ((ioctl.ioctl_addr >> NV_AW) != {ADDR_W{1'b0}});

    // Next-state decode; a read is only accepted from IDLE with a matching upload session.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ioctl.ioctl_rd && ioctl.ioctl_upload && (ioctl.ioctl_index == NV_INDEX)) begin
                    accept_s     = 1'b1;
                    next_state_s = ADDR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR:    next_state_s = DATA;
            DATA:    next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Read datapath; out-of-range reads leave the RAM address untouched and return the fill byte.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wait_r    <= 1'b0;
            din_r     <= 8'h00;
            nv_addr_r <= {NV_AW{1'b0}};
            oor_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                wait_r <= 1'b1;
                oor_r  <= oor_s;
                if (!oor_s) begin
                    nv_addr_r <= ioctl.ioctl_addr[NV_AW-1:0];
                end
            end else if (state_r == DONE) begin
                wait_r <= 1'b0;
            end
            if (state_r == DATA) begin
                din_r <= oor_r ? OOR_FILL : pad_byte(nv_q);
            end
        end
    end

    assign ioctl.ioctl_wait = wait_r;
    assign ioctl.ioctl_din  = din_r;
    assign nv_addr          = nv_addr_r;

`ifdef NVRAM_AUTOSAVE_EN
    logic upload_req_s;

    nvram_quiet_timer #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet_timer (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cpu_nv_we  (cpu_nv_we),
        .upload_req (upload_req_s)
    );

    assign ioctl.ioctl_upload_req = upload_req_s;
`else
    logic unused_s;
    assign unused_s = ^{cpu_nv_we, QUIET_CYCLES};
    assign ioctl.ioctl_upload_req = 1'b0;
`endif

endmodule

// File: doc/nvram_upload.md
NVRAM_UPLOAD -- requirements
Module: nvram_upload

Interface
- REQ-001 Parameter NV_INDEX, default 8'd4: ioctl_index value that selects the NVRAM image.
- REQ-002 Parameter NV_AW, default 10: NVRAM address width (1K x 4 CMOS).
- REQ-003 Parameter QUIET_CYCLES, default 24'd4800000: write-quiet interval before an upload request (100 ms at 48 MHz).
- REQ-004 clk_sys  in  1  system clock; every register in the block is clocked on its rising edge.
- REQ-005 reset  in  1  synchronous, active-high reset.
- REQ-006 ioctl_upload  in  1  HPS upload session active.
- REQ-007 ioctl_index  in  8  image index for the current session.
- REQ-008 ioctl_addr  in  17  byte address requested by HPS.
- REQ-009 ioctl_rd  in  1  one-cycle read strobe from HPS.
- REQ-010 ioctl_din  out  8  byte returned to HPS.
- REQ-011 ioctl_wait  out  1  stall request to HPS; HPS issues no ioctl_rd while high.
- REQ-012 ioctl_upload_req  out  1  one-cycle request that HPS start an upload.
- REQ-013 nv_addr  out  NV_AW  address to the dedicated read port of the NVRAM.
- REQ-014 nv_q  in  4  NVRAM read data, valid one cycle after nv_addr.
- REQ-015 cpu_nv_we  in  1  CPU write strobe into the NVRAM (activity monitor only).

Function
- REQ-016 FSM states: IDLE, ADDR, DATA, DONE.
- REQ-017 IDLE -> ADDR on ioctl_rd=1 with ioctl_upload=1 and ioctl_index==NV_INDEX; in the same cycle, latch ioctl_addr[NV_AW-1:0] into nv_addr and set ioctl_wait=1 from the next cycle.
- REQ-018 ADDR -> DATA unconditionally, to cover the one-cycle RAM latency.
- REQ-019 DATA -> DONE: register ioctl_din = {4'hF, nv_q}.
- REQ-020 DONE -> IDLE: clear ioctl_wait; ioctl_din holds until the next accepted read.
- REQ-021 Read latency: ioctl_wait is high for exactly 3 cycles, and ioctl_din is valid the cycle ioctl_wait falls.
- REQ-022 A read with ioctl_addr >= 2**NV_AW returns 8'hFF; the NVRAM is not addressed and the timing is the same.
- REQ-023 ioctl_rd while not in IDLE is ignored.
- REQ-024 A read with a non-matching index or ioctl_upload=0 leaves ioctl_din and ioctl_wait unchanged.
- REQ-025 ioctl_upload falling mid-transaction: the FSM completes to IDLE normally.

Reset
- REQ-026 On reset: state=IDLE, ioctl_wait=0, ioctl_din=8'h00, nv_addr=0, ioctl_upload_req=0, dirty=0, quiet counter=0.
- REQ-027 Reset asserted mid-transaction aborts it in the same cycle, with no upload_req pulse.

Configuration
- REQ-028 Macro NVRAM_AUTOSAVE_EN defined: cpu_nv_we sets dirty and reloads the quiet counter to QUIET_CYCLES.
- REQ-029 With NVRAM_AUTOSAVE_EN defined, the counter decrements while dirty and nonzero.
- REQ-030 With NVRAM_AUTOSAVE_EN defined, when the counter reaches 0 with dirty=1: pulse ioctl_upload_req for one cycle and clear dirty.
- REQ-031 With NVRAM_AUTOSAVE_EN defined, a cpu_nv_we in the same cycle as expiry wins: reload the counter, no pulse.
- REQ-032 With NVRAM_AUTOSAVE_EN defined, dirty is not cleared by an active upload.
- REQ-033 Macro NVRAM_AUTOSAVE_EN undefined: ioctl_upload_req is constant 0, cpu_nv_we is unused, and no counter is synthesized.

Structure
- REQ-034 Package nvram_pkg holds the FSM state enum, the pad nibble constant 4'hF, and the out-of-range fill constant 8'hFF.
- REQ-035 One sub-module, nvram_quiet_timer, implements the dirty flag and quiet counter; it is instantiated only under NVRAM_AUTOSAVE_EN.

Verification
- REQ-036 NVRAM preset addr 0x005=4'h7; upload with index 4, rd at addr 5 -> ioctl_wait high 3 cycles, ioctl_din=8'hF7.
- REQ-037 rd at addr 0x400 with NV_AW=10 -> ioctl_din=8'hFF, ioctl_wait high 3 cycles.
- REQ-038 rd with index 0 -> ioctl_wait stays 0, ioctl_din unchanged; a second rd during ioctl_wait is ignored.
- REQ-039 With NVRAM_AUTOSAVE_EN and QUIET_CYCLES=10, one cpu_nv_we -> single upload_req pulse 10 cycles later.
- REQ-040 With NVRAM_AUTOSAVE_EN and QUIET_CYCLES=10, writes every 5 cycles -> no pulse until 10 cycles after the last write.
- REQ-041 Reset in ADDR state -> next cycle ioctl_wait=0, state IDLE; without the macro, ioctl_upload_req stays 0 under writes.
